// File: rtl/aud_player.sv
// Audio playback engine: SRAM samples serialized MSB-first onto I2S DACDAT on BCLK.
// Optional build macro AUD_PLAYER_INTERP_EN: linear interpolation in slow mode.
module aud_player (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_lrc,
    input  logic        i_start,
    input  logic        i_pause,
    input  logic        i_stop,
    input  logic        i_fast,
    input  logic [2:0]  i_speed,
    input  logic [19:0] i_end_addr,
    input  logic [15:0] i_sram_data,
    output logic [19:0] o_address,
    output logic        o_dacdat,
    output logic        o_done
);
    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_PAUSE, S_DONE} state_t;

    state_t      state, state_nx;
    logic [19:0] addr, addr_nx;
    logic [2:0]  k, k_nx;
    logic [15:0] sr, sr_nx;
    logic [4:0]  cnt, cnt_nx;
    logic        dac_nx;
    logic        lrc_prev;
    logic        pause_pend, pause_pend_nx;
    logic        armed, armed_nx;

    logic        fall, rise;
    logic [3:0]  bit_idx;
    logic [20:0] next_pos;
    logic [2:0]  k_adv;
    logic [15:0] load_val;

    assign fall    = lrc_prev & ~i_lrc;
    assign rise    = ~lrc_prev & i_lrc;
    assign bit_idx = cnt[3:0] - 4'd1;
    assign o_done  = (state == S_DONE);

`ifdef AUD_PLAYER_INTERP_EN
    logic [15:0]        s1, s1_nx;
    logic [1:0]         fcnt, fcnt_nx;
    logic [3:0]         n_r, n_r_nx;
    logic               slow_r, slow_r_nx;
    logic [20:0]        s1_pos;
    logic [19:0]        s1_addr;
    logic signed [16:0] diff;
    logic signed [19:0] prod;
    logic [15:0]        step;

    assign s1_pos   = {1'b0, addr} + 21'd1;
    assign s1_addr  = (s1_pos > {1'b0, i_end_addr}) ? i_end_addr : s1_pos[19:0];
    assign diff     = $signed({s1[15], s1}) - $signed({i_sram_data[15], i_sram_data});
    assign prod     = $signed({{3{diff[16]}}, diff}) * $signed({17'd0, k});
    assign step     = 16'(prod / $signed({16'd0, n_r}));
    assign load_val = slow_r ? (i_sram_data + step) : i_sram_data;
    // s1 is fetched by pointing the SRAM at the next sample for two cycles after the boundary
    assign o_address = (fcnt != 2'd0) ? s1_addr : addr;
`else
    assign load_val  = i_sram_data;
    assign o_address = addr;
`endif

    always_comb begin
        k_adv = '0;
        if (i_fast) begin
            next_pos = {1'b0, addr} + {18'd0, i_speed} + 21'd1;
        end else if (k >= i_speed) begin
            next_pos = {1'b0, addr} + 21'd1;
        end else begin
            next_pos = {1'b0, addr};
            k_adv    = k + 3'd1;
        end
    end

    always_comb begin
        state_nx      = state;
        addr_nx       = addr;
        k_nx          = k;
        sr_nx         = sr;
        cnt_nx        = cnt;
        pause_pend_nx = pause_pend;
        armed_nx      = armed;
        dac_nx        = 1'b0;
`ifdef AUD_PLAYER_INTERP_EN
        s1_nx     = (fcnt == 2'd1) ? i_sram_data : s1;
        fcnt_nx   = (fcnt == 2'd0) ? 2'd0 : fcnt - 2'd1;
        n_r_nx    = n_r;
        slow_r_nx = slow_r;
`endif
        // A started half-frame drains even after PLAY is left for PAUSE or DONE
        if (cnt != 5'd0) begin
            dac_nx = sr[bit_idx];
            cnt_nx = cnt - 5'd1;
        end
        if (i_stop && (state == S_PLAY || state == S_PAUSE)) begin
            state_nx      = S_IDLE;
            addr_nx       = '0;
            k_nx          = '0;
            cnt_nx        = '0;
            dac_nx        = 1'b0;
            pause_pend_nx = 1'b0;
            armed_nx      = 1'b0;
`ifdef AUD_PLAYER_INTERP_EN
            fcnt_nx = '0;
`endif
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        state_nx      = S_PLAY;
                        addr_nx       = '0;
                        k_nx          = '0;
                        armed_nx      = 1'b0;
                        pause_pend_nx = 1'b0;
`ifdef AUD_PLAYER_INTERP_EN
                        n_r_nx    = {1'b0, i_speed} + 4'd1;
                        slow_r_nx = ~i_fast;
`endif
                    end
                end
                S_PLAY: begin
                    if (i_pause) pause_pend_nx = 1'b1;
                    if (fall) begin
                        sr_nx    = load_val;
                        cnt_nx   = 5'd16;
                        dac_nx   = 1'b0;
                        armed_nx = 1'b1;
                    end else if (rise && armed) begin
                        cnt_nx = 5'd16;
                        dac_nx = 1'b0;
                        if (next_pos > {1'b0, i_end_addr}) begin
                            state_nx = S_DONE;
                        end else begin
                            addr_nx = next_pos[19:0];
                            k_nx    = k_adv;
`ifdef AUD_PLAYER_INTERP_EN
                            fcnt_nx   = 2'd2;
                            n_r_nx    = {1'b0, i_speed} + 4'd1;
                            slow_r_nx = ~i_fast;
`endif
                            if (pause_pend || i_pause) begin
                                state_nx      = S_PAUSE;
                                pause_pend_nx = 1'b0;
                            end
                        end
                    end
                end
                S_PAUSE: begin
                    if (!i_pause && i_start) begin
                        state_nx = S_PLAY;
                        armed_nx = 1'b0;
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_IDLE;
            addr       <= '0;
            k          <= '0;
            sr         <= '0;
            cnt        <= '0;
            o_dacdat   <= 1'b0;
            lrc_prev   <= 1'b0;
            pause_pend <= 1'b0;
            armed      <= 1'b0;
`ifdef AUD_PLAYER_INTERP_EN
            s1     <= '0;
            fcnt   <= '0;
            n_r    <= 4'd1;
            slow_r <= 1'b0;
`endif
        end else begin
            state      <= state_nx;
            addr       <= addr_nx;
            k          <= k_nx;
            sr         <= sr_nx;
            cnt        <= cnt_nx;
            o_dacdat   <= dac_nx;
            lrc_prev   <= i_lrc;
            pause_pend <= pause_pend_nx;
            armed      <= armed_nx;
`ifdef AUD_PLAYER_INTERP_EN
            s1     <= s1_nx;
            fcnt   <= fcnt_nx;
            n_r    <= n_r_nx;
            slow_r <= slow_r_nx;
`endif
        end
    end
endmodule

// File: tb/tb_aud_player.sv
// Directed bench for aud_player: I2S serialization, fast/slow playback, pause, stop, reset.
module tb_aud_player;
    logic        clk, rst_n, lrc, start, pause, stop, fast, dacdat, done;
    logic [2:0]  speed;
    logic [19:0] end_addr, address;
    logic [15:0] sram_data;
    logic [15:0] mem [16];
    int checks = 0;
    int errors = 0;

    aud_player dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_lrc(lrc), .i_start(start), .i_pause(pause),
        .i_stop(stop), .i_fast(fast), .i_speed(speed), .i_end_addr(end_addr),
        .i_sram_data(sram_data), .o_address(address), .o_dacdat(dacdat), .o_done(done)
    );

    initial begin clk = 1'b0; forever #5 clk = ~clk; end
    // 32-cycle half-frames; LRC moves 3 ns before a rising BCLK edge
    initial begin lrc = 1'b0; #2; forever #320 lrc = ~lrc; end
    always @(posedge clk) sram_data <= (address < 20'd16) ? mem[address[3:0]] : 16'h0000;
    initial begin #500000; $display("FAIL watchdog timeout"); $fatal(1); end

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic align_and_start();
        @(posedge lrc);
        repeat (4) @(negedge clk);
        pulse_start();
    endtask

    task automatic get_half(input logic rising, output logic [15:0] w, output logic quiet);
        w = '0; quiet = 1'b1;
        if (rising) @(posedge lrc); else @(negedge lrc);
        @(posedge clk); #1;
        if (dacdat !== 1'b0) quiet = 1'b0;
        for (int b = 15; b >= 0; b--) begin
            @(posedge clk); #1;
            w[b] = dacdat;
        end
        @(posedge clk); #1;
        if (dacdat !== 1'b0) quiet = 1'b0;
    endtask

    task automatic get_frame(output logic [15:0] l, output logic [15:0] r, output logic quiet);
        logic q0, q1;
        get_half(1'b0, l, q0);
        get_half(1'b1, r, q1);
        quiet = q0 & q1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0;
        fast = 1'b1; speed = 3'd0; end_addr = 20'd3;
        repeat (3) @(negedge clk);
        checks++; if (address !== 20'd0) begin errors++; $display("FAIL reset_addr got %h expected 0", address); end
        checks++; if (dacdat !== 1'b0) begin errors++; $display("FAIL reset_dacdat got %b expected 0", dacdat); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", done); end
        rst_n = 1'b1;
        repeat (3) @(posedge clk); #1;
        checks++; if (done !== 1'b0 || address !== 20'd0) begin
            errors++; $display("FAIL idle_after_reset got done=%b addr=%h expected 0/0", done, address);
        end
    endtask

    task automatic test_play();
        logic [15:0] l, r, e [4];
        logic q;
        e[0] = 16'h8001; e[1] = 16'h1234; e[2] = 16'hFFFF; e[3] = 16'h0000;
        for (int i = 0; i < 16; i++) mem[i] = 16'h7E7E;
        for (int i = 0; i < 4; i++) mem[i] = e[i];
        do_reset();
        fast = 1'b1; speed = 3'd0; end_addr = 20'd3;
        align_and_start();
        for (int f = 0; f < 4; f++) begin
            get_frame(l, r, q);
            checks++; if (l !== e[f]) begin errors++; $display("FAIL play_left[%0d] got %h expected %h", f, l, e[f]); end
            checks++; if (r !== e[f]) begin errors++; $display("FAIL play_right[%0d] got %h expected %h", f, r, e[f]); end
            checks++; if (q !== 1'b1) begin errors++; $display("FAIL play_quiet_slots[%0d] got %b expected 1", f, q); end
            checks++; if (address !== 20'((f < 3) ? f + 1 : 3)) begin
                errors++; $display("FAIL play_addr[%0d] got %h expected %h", f, address, (f < 3) ? f + 1 : 3);
            end
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL play_done got %b expected 1", done); end
        get_frame(l, r, q);
        checks++; if (l !== 16'h0 || r !== 16'h0 || q !== 1'b1) begin
            errors++; $display("FAIL done_silent got %h/%h expected 0000/0000", l, r);
        end
        pulse_start();
        get_frame(l, r, q);
        checks++; if (l !== 16'h8001 || r !== 16'h8001) begin
            errors++; $display("FAIL restart_from_done got %h/%h expected 8001/8001", l, r);
        end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL restart_done got %b expected 0", done); end
    endtask

    task automatic test_fast_skip();
        logic [15:0] l, r, e [4];
        logic q;
        e[0] = 16'hA000; e[1] = 16'hA003; e[2] = 16'hA006; e[3] = 16'hA009;
        for (int i = 0; i < 16; i++) mem[i] = 16'h1100 + 16'(i);
        mem[0] = e[0]; mem[3] = e[1]; mem[6] = e[2]; mem[9] = e[3];
        do_reset();
        fast = 1'b1; speed = 3'd2; end_addr = 20'd9;
        align_and_start();
        for (int f = 0; f < 4; f++) begin
            get_frame(l, r, q);
            checks++; if (l !== e[f] || r !== e[f]) begin
                errors++; $display("FAIL fast3_frame[%0d] got %h/%h expected %h", f, l, r, e[f]);
            end
        end
        checks++; if (done !== 1'b1 || address !== 20'd9) begin
            errors++; $display("FAIL fast3_end got done=%b addr=%h expected 1/00009", done, address);
        end
    endtask

    task automatic test_slow();
        logic [15:0] l, r, e [8];
        logic q;
`ifdef AUD_PLAYER_INTERP_EN
        e[0] = 16'h0100; e[1] = 16'h0140; e[2] = 16'h0180; e[3] = 16'h01C0;
`else
        e[0] = 16'h0100; e[1] = 16'h0100; e[2] = 16'h0100; e[3] = 16'h0100;
`endif
        e[4] = 16'h0200; e[5] = 16'h0200; e[6] = 16'h0200; e[7] = 16'h0200;
        for (int i = 0; i < 16; i++) mem[i] = 16'h7777;
        mem[0] = 16'h0100; mem[1] = 16'h0200;
        do_reset();
        fast = 1'b0; speed = 3'd3; end_addr = 20'd1;
        align_and_start();
        for (int f = 0; f < 8; f++) begin
            get_frame(l, r, q);
            checks++; if (l !== e[f] || r !== e[f]) begin
                errors++; $display("FAIL slow4_frame[%0d] got %h/%h expected %h", f, l, r, e[f]);
            end
        end
        checks++; if (done !== 1'b1 || address !== 20'd1) begin
            errors++; $display("FAIL slow4_end got done=%b addr=%h expected 1/00001", done, address);
        end
    endtask

    task automatic test_pause();
        logic [15:0] l, r;
        logic q;
        for (int i = 0; i < 16; i++) mem[i] = 16'hC000 + 16'(i * 16'h0111);
        do_reset();
        fast = 1'b1; speed = 3'd0; end_addr = 20'd15;
        align_and_start();
        get_frame(l, r, q);
        fork
            get_frame(l, r, q);
            begin
                @(negedge lrc);
                repeat (6) @(negedge clk);
                pause = 1'b1;
                @(negedge clk);
                pause = 1'b0;
            end
        join
        checks++; if (l !== mem[1] || r !== mem[1]) begin
            errors++; $display("FAIL pause_frame_completes got %h/%h expected %h", l, r, mem[1]);
        end
        checks++; if (address !== 20'd2) begin errors++; $display("FAIL pause_addr got %h expected 00002", address); end
        get_frame(l, r, q);
        checks++; if (l !== 16'h0 || r !== 16'h0 || q !== 1'b1) begin
            errors++; $display("FAIL paused_silent got %h/%h expected 0000/0000", l, r);
        end
        checks++; if (address !== 20'd2 || done !== 1'b0) begin
            errors++; $display("FAIL paused_hold got addr=%h done=%b expected 00002/0", address, done);
        end
        pulse_start();
        get_frame(l, r, q);
        checks++; if (l !== mem[2] || r !== mem[2]) begin
            errors++; $display("FAIL resume_frame got %h/%h expected %h", l, r, mem[2]);
        end
        checks++; if (address !== 20'd3) begin errors++; $display("FAIL resume_addr got %h expected 00003", address); end
    endtask

    task automatic test_stop_pause();
        logic [15:0] l, r;
        logic q;
        int ones;
        for (int i = 0; i < 16; i++) mem[i] = 16'hFFFF;
        do_reset();
        fast = 1'b1; speed = 3'd0; end_addr = 20'd15;
        align_and_start();
        get_frame(l, r, q);
        get_frame(l, r, q);
        @(negedge lrc);
        repeat (8) @(negedge clk);
        checks++; if (dacdat !== 1'b1) begin errors++; $display("FAIL stop_pre_bit got %b expected 1", dacdat); end
        stop = 1'b1; pause = 1'b1;
        @(posedge clk); #1;
        checks++; if (address !== 20'd0) begin errors++; $display("FAIL stop_addr got %h expected 00000", address); end
        checks++; if (dacdat !== 1'b0) begin errors++; $display("FAIL stop_dacdat got %b expected 0", dacdat); end
        @(negedge clk); stop = 1'b0; pause = 1'b0;
        ones = 0;
        repeat (12) begin @(posedge clk); #1; if (dacdat === 1'b1) ones++; end
        checks++; if (ones !== 0) begin errors++; $display("FAIL stop_rest_of_half got %0d ones expected 0", ones); end
        get_frame(l, r, q);
        checks++; if (l !== 16'h0 || r !== 16'h0 || address !== 20'd0) begin
            errors++; $display("FAIL stop_idle got %h/%h addr=%h expected 0000/0000/00000", l, r, address);
        end
    endtask

    task automatic test_async_reset();
        logic [15:0] l, r;
        logic q;
        for (int i = 0; i < 16; i++) mem[i] = 16'hFFFF;
        do_reset();
        fast = 1'b1; speed = 3'd0; end_addr = 20'd15;
        align_and_start();
        get_frame(l, r, q);
        @(negedge lrc);
        repeat (5) @(posedge clk);
        #3;
        checks++; if (dacdat !== 1'b1 || address !== 20'd1) begin
            errors++; $display("FAIL areset_pre got dacdat=%b addr=%h expected 1/00001", dacdat, address);
        end
        rst_n = 1'b0;
        #1;
        checks++; if (dacdat !== 1'b0) begin errors++; $display("FAIL areset_dacdat got %b expected 0", dacdat); end
        checks++; if (address !== 20'd0) begin errors++; $display("FAIL areset_addr got %h expected 00000", address); end
        @(negedge clk); rst_n = 1'b1;
        get_frame(l, r, q);
        checks++; if (l !== 16'h0 || r !== 16'h0) begin
            errors++; $display("FAIL areset_no_restart got %h/%h expected 0000/0000", l, r);
        end
    endtask

    task automatic test_end_zero();
        logic [15:0] l, r;
        logic q;
        for (int i = 0; i < 16; i++) mem[i] = 16'hFFFF;
        mem[0] = 16'h5A5A;
        do_reset();
        fast = 1'b1; speed = 3'd0; end_addr = 20'd0;
        align_and_start();
        get_frame(l, r, q);
        checks++; if (l !== 16'h5A5A || r !== 16'h5A5A) begin
            errors++; $display("FAIL end0_frame got %h/%h expected 5a5a", l, r);
        end
        checks++; if (done !== 1'b1 || address !== 20'd0) begin
            errors++; $display("FAIL end0_done got done=%b addr=%h expected 1/00000", done, address);
        end
        get_frame(l, r, q);
        checks++; if (l !== 16'h0 || r !== 16'h0) begin
            errors++; $display("FAIL end0_silent got %h/%h expected 0000/0000", l, r);
        end
    endtask

    initial begin
        test_reset();
        test_play();
        test_fast_skip();
        test_slow();
        test_pause();
        test_stop_pause();
        test_async_reset();
        test_end_zero();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
